// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Grant encoding and the arbitration helper live here so both files agree on them.
package wb_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic GNT_ALU   = 1'b0;
  localparam logic GNT_MEM   = 1'b1;
  localparam int   REG_COUNT = 32;

  // Round-robin pick between two requesters; last_grant only matters on a conflict.
  function automatic logic pick_grant(input logic alu_v, input logic mem_v,
                                      input logic last_grant);
    if (alu_v && mem_v) return (last_grant == GNT_ALU) ? GNT_MEM : GNT_ALU;
    else if (mem_v)     return GNT_MEM;
    else                return GNT_ALU;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared when the write commits to the register file.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     sb_set,
  input  reg_idx_t sb_rd,
  input  logic     rf_we,
  input  reg_idx_t rf_waddr,
  input  reg_idx_t chk_rs1,
  input  reg_idx_t chk_rs2,
  output logic     busy_rs1,
  output logic     busy_rs2
);

  logic [REG_COUNT-1:0] pending, pending_d;

  // Clear first, then set, so an issue racing a commit to the same register keeps it busy.
  always_comb begin
    pending_d = pending;
    if (rf_we)
      pending_d[rf_waddr] = 1'b0;
    if (sb_set && (sb_rd != '0))
      pending_d[sb_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_d;
  end

  assign busy_rs1 = pending[chk_rs1];
  assign busy_rs2 = pending[chk_rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// Define WB_SCOREBOARD_EN to add the pending-write scoreboard and its sb_/chk_/busy_ ports.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_valid,
  input  reg_idx_t     alu_rd,
  input  logic [n-1:0] alu_data,
  output logic         alu_ready,
  input  logic         mem_valid,
  input  reg_idx_t     mem_rd,
  input  logic [n-1:0] mem_data,
  output logic         mem_ready,
`ifdef WB_SCOREBOARD_EN
  input  logic         sb_set,
  input  reg_idx_t     sb_rd,
  input  reg_idx_t     chk_rs1,
  input  reg_idx_t     chk_rs2,
  output logic         busy_rs1,
  output logic         busy_rs2,
`endif
  output logic         rf_we,
  output reg_idx_t     rf_waddr,
  output logic [n-1:0] rf_wdata
);

  logic     last_grant;
  logic     gnt;
  logic     xfer;
  reg_idx_t win_rd;
  logic [n-1:0] win_data;

  // Ready is held low during reset so nothing is consumed that reset would then drop.
  always_comb begin
    gnt       = pick_grant(alu_valid, mem_valid, last_grant);
    alu_ready = !rst && alu_valid && (gnt == GNT_ALU);
    mem_ready = !rst && mem_valid && (gnt == GNT_MEM);
    xfer      = alu_ready || mem_ready;
    win_rd    = (gnt == GNT_MEM) ? mem_rd   : alu_rd;
    win_data  = (gnt == GNT_MEM) ? mem_data : alu_data;
  end

  // x0 requests are consumed and advance the round-robin but never assert rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= GNT_ALU;
    end else if (xfer) begin
      rf_we      <= (win_rd != '0);
      rf_waddr   <= win_rd;
      rf_wdata   <= win_data;
      last_grant <= gnt;
    end else begin
      rf_we      <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_rd    (sb_rd),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2)
  );
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; scoreboard scenarios run when WB_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  reg_idx_t    alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready;
  logic        rf_we;
  reg_idx_t    rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_set = 1'b0;
  reg_idx_t    sb_rd = '0, chk_rs1 = '0, chk_rs2 = '0;
  logic        busy_rs1, busy_rs2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.n(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
`ifdef WB_SCOREBOARD_EN
    .sb_set    (sb_set),
    .sb_rd     (sb_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2),
`endif
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

`ifndef WB_SCOREBOARD_EN
  assign busy_rs1 = 1'b0;
  assign busy_rs2 = 1'b0;
`endif

  // Inputs change on the falling edge; combinational outputs are sampled #1 later,
  // registered outputs on the falling edge after the rising edge that loaded them.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2;
    @(negedge clk);
    @(negedge clk);
    total++; if (rf_we !== 1'b0)     begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    total++; if (rf_waddr !== 5'd0)  begin bad++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    total++; if ({alu_ready, mem_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, mem_ready}); end
`ifdef WB_SCOREBOARD_EN
    total++; if ({busy_rs1, busy_rs2} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", {busy_rs1, busy_rs2}); end
`endif
    rst = 1'b0;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b01) begin bad++; $display("FAIL post_reset_ready alu/mem got=%b exp=01", {alu_ready, mem_ready}); end
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {alu_ready, mem_ready}); end
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if ({rf_we, rf_waddr} !== {1'b1, 5'd5}) begin bad++; $display("FAIL single_write we/addr got=%b/%0d exp=1/5", rf_we, rf_waddr); end
    total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", rf_wdata); end
    @(negedge clk);
    total++; if (rf_we !== 1'b0)    begin bad++; $display("FAIL single_we_drop got=%b exp=0", rf_we); end
    total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL single_addr_hold got=%0d exp=5", rf_waddr); end
  endtask

  // last_grant is ALU here, so a held conflict alternates MEM, ALU, MEM, ALU.
  task automatic test_conflict();
    logic exp_mem;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      exp_mem = (i % 2 == 0);
      #1;
      total++; if (alu_ready && mem_ready) begin bad++; $display("FAIL conflict_both_ready cycle=%0d got=11 exp=one-hot", i); end
      total++; if ({alu_ready, mem_ready} !== {!exp_mem, exp_mem}) begin bad++; $display("FAIL conflict_grant cycle=%0d got=%b exp=%b", i, {alu_ready, mem_ready}, {!exp_mem, exp_mem}); end
      @(negedge clk);
      if (i == 3) begin alu_valid = 1'b0; mem_valid = 1'b0; end
      total++; if ({rf_we, rf_waddr} !== {1'b1, exp_mem ? 5'd4 : 5'd3}) begin bad++; $display("FAIL conflict_write cycle=%0d got=%b/%0d exp=1/%0d", i, rf_we, rf_waddr, exp_mem ? 4 : 3); end
      total++; if (rf_wdata !== (exp_mem ? 32'h22 : 32'h11)) begin bad++; $display("FAIL conflict_data cycle=%0d got=%h exp=%h", i, rf_wdata, exp_mem ? 32'h22 : 32'h11); end
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
    #1;
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", mem_ready); end
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", rf_we); end
    // The x0 request made MEM the last winner, so the next conflict goes to ALU.
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'hAA;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hBB;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b10) begin bad++; $display("FAIL x0_next_grant got=%b exp=10", {alu_ready, mem_ready}); end
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hAA}) begin bad++; $display("FAIL x0_next_write got=%b/%0d/%h exp=1/9/aa", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
  endtask

`ifdef WB_SCOREBOARD_EN
  task automatic test_scoreboard();
    sb_set = 1'b1; sb_rd = 5'd7; chk_rs1 = 5'd7; chk_rs2 = 5'd8;
    @(negedge clk);
    sb_set = 1'b0;
    total++; if ({busy_rs1, busy_rs2} !== 2'b10) begin bad++; $display("FAIL sb_set_busy got=%b exp=10", {busy_rs1, busy_rs2}); end
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if ({rf_we, busy_rs1} !== 2'b11) begin bad++; $display("FAIL sb_busy_during_we got=%b exp=11", {rf_we, busy_rs1}); end
    @(negedge clk);
    total++; if ({rf_we, busy_rs1} !== 2'b00) begin bad++; $display("FAIL sb_busy_cleared got=%b exp=00", {rf_we, busy_rs1}); end
    // Re-issue of x7 on the same edge that commits the earlier x7 write.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h78;
    @(negedge clk);
    mem_valid = 1'b0;
    sb_set = 1'b1; sb_rd = 5'd7;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL sb_race_we got=%b exp=1", rf_we); end
    @(negedge clk);
    sb_set = 1'b0;
    total++; if (busy_rs1 !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b exp=1", busy_rs1); end
    sb_set = 1'b1; sb_rd = 5'd0; chk_rs2 = 5'd0;
    @(negedge clk);
    sb_set = 1'b0;
    total++; if (busy_rs2 !== 1'b0) begin bad++; $display("FAIL sb_x0_busy got=%b exp=0", busy_rs2); end
  endtask
`endif

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h00C0FFEE;
    rst = 1'b1;
    chk_rs1 = 5'd7;
    #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", alu_ready); end
    @(negedge clk);
    rst = 1'b0;
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'h0}) begin bad++; $display("FAIL rstmid_outputs got=%b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
`ifdef WB_SCOREBOARD_EN
    total++; if (busy_rs1 !== 1'b0) begin bad++; $display("FAIL rstmid_pending got=%b exp=0", busy_rs1); end
`endif
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL rstmid_regrant got=%b exp=1", alu_ready); end
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'h00C0FFEE}) begin bad++; $display("FAIL rstmid_write got=%b/%0d/%h exp=1/12/00c0ffee", rf_we, rf_waddr, rf_wdata); end
    // ALU won last; a fresh conflict must go to MEM.
    alu_valid = 1'b1; mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'h13;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b01) begin bad++; $display("FAIL rstmid_conflict got=%b exp=01", {alu_ready, mem_ready}); end
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_conflict();
    test_x0();
`ifdef WB_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
